// File: rtl/sec_countdown_pkg.sv
// Shared constants and helpers for the mm:ss countdown timer.
// Packing of the 16-bit value is {min_tens, min_ones, sec_tens, sec_ones}.
package sec_countdown_pkg;

   typedef logic [15:0] bcd_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [3:0] BCD_MAX_ONES = 4'd9;
   localparam logic [3:0] BCD_MAX_STEN = 4'd5;

   localparam int MT_LSB = 12;
   localparam int MO_LSB = 8;
   localparam int ST_LSB = 4;
   localparam int SO_LSB = 0;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   function automatic bcd_t clamp_bcd(input bcd_t v);
      return {clamp_digit(v[MT_LSB +: 4], BCD_MAX_ONES),
              clamp_digit(v[MO_LSB +: 4], BCD_MAX_ONES),
              clamp_digit(v[ST_LSB +: 4], BCD_MAX_STEN),
              clamp_digit(v[SO_LSB +: 4], BCD_MAX_ONES)};
   endfunction

endpackage

// File: rtl/sec_edge_tick.sv
// Turns toggles of the synchronous 1 Hz wave into single-cycle ticks.
// The arm flag suppresses a false edge in the first cycle after reset.
module sec_edge_tick #(
   parameter int BOTH_EDGES = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sec_in,
   output logic o_tick
);

   logic r_sec_q;
   logic r_arm;
   logic w_edge;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sec_q <= 1'b0;
         r_arm   <= 1'b0;
      end else begin
         r_sec_q <= i_sec_in;
         r_arm   <= 1'b1;
      end
   end

   assign w_edge = (BOTH_EDGES != 0) ? (i_sec_in ^ r_sec_q) : (i_sec_in & ~r_sec_q);
   assign o_tick = r_arm & w_edge;

endmodule

// File: rtl/sec_countdown.sv
// mm:ss BCD countdown; each sec_in toggle (or rising edge) removes one second.
//  state | meaning
//  IDLE  | loaded value shown, waiting for start
//  RUN   | decrementing on every tick
//  PAUSE | ticks ignored, start resumes
//  DONE  | reached 00:00, holds until load
module sec_countdown
   import sec_countdown_pkg::*;
#(
   parameter int BOTH_EDGES = 1,
   parameter int DIV_FLOOR  = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sec_in,
   input  logic        i_load,
   input  logic [15:0] i_set_bcd,
   input  logic        i_start,
   input  logic        i_pause,
   output logic [15:0] o_digits,
   output logic        o_running,
   output logic        o_expired,
   output logic        o_done_pulse
);

   logic [1:0] r_state;
   bcd_t       r_digits;
   logic       r_done_pulse;

   logic [1:0] w_state_nxt;
   bcd_t       w_digits_nxt;
   bcd_t       w_dec;
   logic       w_enter_done;
   logic       w_tick;

   // DIV_FLOOR only exists so benches can share a parameter list; no hardware.
   if (DIV_FLOOR != 1) begin : g_div_floor_unused
   end

   sec_edge_tick #(
      .BOTH_EDGES(BOTH_EDGES)
   ) u_edge_tick (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_sec_in(i_sec_in),
      .o_tick  (w_tick)
   );

   function automatic bcd_t bcd_dec(input bcd_t v);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = v;
      if (so != 4'd0) begin
         so = so - 4'd1;
      end else begin
         so = BCD_MAX_ONES;
         if (st != 4'd0) begin
            st = st - 4'd1;
         end else begin
            st = BCD_MAX_STEN;
            if (mo != 4'd0) begin
               mo = mo - 4'd1;
            end else begin
               mo = BCD_MAX_ONES;
               mt = mt - 4'd1;
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   assign w_dec = bcd_dec(r_digits);

   always_comb begin
      w_state_nxt  = r_state;
      w_digits_nxt = r_digits;
      w_enter_done = 1'b0;
      if (i_load) begin
         w_state_nxt  = ST_IDLE;
         w_digits_nxt = clamp_bcd(i_set_bcd);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  if (r_digits == 16'h0000) begin
                     w_state_nxt  = ST_DONE;
                     w_enter_done = 1'b1;
                  end else begin
                     w_state_nxt = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               // pause outranks a coincident tick: the second is not consumed
               if (i_pause) begin
                  w_state_nxt = ST_PAUSE;
               end else if (w_tick) begin
                  w_digits_nxt = w_dec;
                  if (w_dec == 16'h0000) begin
                     w_state_nxt  = ST_DONE;
                     w_enter_done = 1'b1;
                  end
               end
            end
            ST_PAUSE: begin
               if (i_start) w_state_nxt = ST_RUN;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_digits     <= 16'h0000;
         r_done_pulse <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_digits     <= w_digits_nxt;
         r_done_pulse <= w_enter_done;
      end
   end

   assign o_digits     = r_digits;
   assign o_running    = (r_state == ST_RUN);
   assign o_expired    = (r_state == ST_DONE);
   assign o_done_pulse = r_done_pulse;

endmodule
